sound_glu_engine: RTL and testbench

//  Next-generation GLU front end: owns the $C03C-$C03F register file, buffers CPU writes to the
//  64K sound RAM in a posted-write FIFO, adds IIgs-style sound RAM reads (one-behind data latch,

---
 rtl/sound_glu_pkg.sv | 29 ++
 rtl/sound_glu_wr_fifo.sv | 41 ++++
 rtl/sound_glu_engine.sv | 204 ++++++++++++++++++++
 tb/tb_sound_glu_engine.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_glu_pkg.sv
// Shared definitions for the GLU front end: register map, ctrl bit layout,
// memory FSM states and the posted-write FIFO entry.
package sound_glu_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_PTR_LO = 2'd2;
    localparam logic [1:0] REG_PTR_HI = 2'd3;

    localparam int CTRL_BUSY     = 7;
    localparam int CTRL_RAM_SEL  = 6;
    localparam int CTRL_AUTO_INC = 5;

    localparam logic [7:0] CTRL_RESET = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT
    } glu_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

endpackage

// File: rtl/sound_glu_wr_fifo.sv
// Posted-write FIFO for sound RAM writes. The head entry stays put until the
// memory side pops it on completion, so the in-flight write occupies a slot.
module sound_glu_wr_fifo
    import sound_glu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      reset_n_i,
    input  logic      push_i,
    input  wr_entry_t wr_entry_i,
    input  logic      pop_i,
    output wr_entry_t rd_entry_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    wr_entry_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign empty_o    = (wr_ptr == rd_ptr);
    assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_entry_o = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i && !full_o)  wr_ptr <= wr_ptr + 1'b1;
            if (pop_i && !empty_o)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= wr_entry_i;
    end

endmodule

// File: rtl/sound_glu_engine.sv
// GLU front end: $C03C-$C03F register file, posted sound RAM writes, one-behind
// sound RAM reads through a single-outstanding SDRAM client, and DOC mix volume scaling.
module sound_glu_engine
    import sound_glu_pkg::*;
#(
    parameter int                    WR_FIFO_DEPTH = 4,
    parameter int                    MEM_ADDR_W    = 21,
    parameter logic [MEM_ADDR_W-1:0] RAM_BASE      = 21'h4000,
    parameter int                    NUM_CH        = 2,
    parameter int                    AUDIO_W       = 16,
    parameter int                    VOL_W         = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        sel_i,
    input  logic [1:0]                  reg_addr_i,
    input  logic                        rw_n_i,
    input  logic                        wr_strobe_i,
    input  logic                        rd_strobe_i,
    input  logic [7:0]                  data_i,
    output logic [7:0]                  data_o,
    output logic [MEM_ADDR_W-1:0]       mem_addr_o,
    output logic                        mem_rd_o,
    output logic                        mem_wr_o,
    output logic [3:0]                  mem_byte_en_o,
    output logic [31:0]                 mem_data_o,
    input  logic [31:0]                 mem_q_i,
    input  logic                        mem_ready_i,
    output logic                        doc_cs_n_o,
    output logic [7:0]                  doc_addr_o,
    output logic [7:0]                  doc_data_o,
    input  logic [7:0]                  doc_data_i,
    input  logic [NUM_CH*AUDIO_W-1:0]   mix_i,
    output logic [NUM_CH*AUDIO_W-1:0]   audio_o,
    output logic                        overflow_o
);
    localparam int PW = AUDIO_W + VOL_W + 2;

    glu_state_t  state;
    logic [6:0]  ctrl;
    logic [7:0]  latch;
    logic [15:0] ptr;
    logic [15:0] cur_addr;
    logic [7:0]  cur_data;
    logic        fetch_pend;
    logic [15:0] fetch_addr;

    logic        fifo_full, fifo_empty, fifo_pop;
    wr_entry_t   fifo_head, fifo_in;

    logic ram_mode, auto_inc, busy;
    logic wr_hit, rd_hit, data_wr, data_rd, ctrl_wr;

    assign ram_mode = ctrl[CTRL_RAM_SEL];
    assign auto_inc = ctrl[CTRL_AUTO_INC];
    assign wr_hit   = sel_i & wr_strobe_i & ~rw_n_i;
    assign rd_hit   = sel_i & rd_strobe_i & rw_n_i;
    assign data_wr  = wr_hit && (reg_addr_i == REG_DATA);
    assign data_rd  = rd_hit && (reg_addr_i == REG_DATA);
    assign ctrl_wr  = wr_hit && (reg_addr_i == REG_CTRL);
    assign busy     = ~fifo_empty | fetch_pend | (state != ST_IDLE);

    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            REG_CTRL:   data_o = {busy, ctrl};
            REG_DATA:   data_o = ram_mode ? latch : doc_data_i;
            REG_PTR_LO: data_o = ptr[7:0];
            REG_PTR_HI: data_o = ptr[15:8];
            default:    data_o = 8'h00;
        endcase
    end

    // Register file, pointer and sticky overflow
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctrl       <= CTRL_RESET[6:0];
            ptr        <= 16'h0000;
            overflow_o <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= data_i[6:0];

            if (wr_hit && reg_addr_i == REG_PTR_LO)
                ptr[7:0] <= data_i;
            else if (wr_hit && reg_addr_i == REG_PTR_HI)
                ptr[15:8] <= data_i;
            else if (((data_wr && ram_mode) || data_rd) && auto_inc)
                ptr <= ptr + 16'd1;

            if (ctrl_wr)
                overflow_o <= 1'b0;
            else if (data_wr && ram_mode && fifo_full)
                overflow_o <= 1'b1;
        end
    end

    assign fifo_in = '{addr: ptr, data: data_i};
    assign fifo_pop = mem_ready_i && (state == ST_WR_REQ || state == ST_WR_WAIT);

    sound_glu_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_i     (data_wr && ram_mode),
        .wr_entry_i (fifo_in),
        .pop_i      (fifo_pop),
        .rd_entry_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Single queued fetch; a newer read replaces an unissued one
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fetch_pend <= 1'b0;
            fetch_addr <= 16'h0000;
        end else if (data_rd && ram_mode) begin
            fetch_pend <= 1'b1;
            fetch_addr <= ptr;
        end else if (state == ST_IDLE && fifo_empty) begin
            fetch_pend <= 1'b0;
        end
    end

    // Memory FSM: writes drain first so a read never passes an older write
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= ST_IDLE;
            mem_wr_o <= 1'b0;
            mem_rd_o <= 1'b0;
            cur_addr <= 16'h0000;
            cur_data <= 8'h00;
            latch    <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_addr <= fifo_head.addr;
                        cur_data <= fifo_head.data;
                        mem_wr_o <= 1'b1;
                        state    <= ST_WR_REQ;
                    end else if (fetch_pend) begin
                        cur_addr <= fetch_addr;
                        mem_rd_o <= 1'b1;
                        state    <= ST_RD_REQ;
                    end
                end
                ST_WR_REQ, ST_WR_WAIT: begin
                    mem_wr_o <= 1'b0;
                    state    <= mem_ready_i ? ST_IDLE : ST_WR_WAIT;
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    mem_rd_o <= 1'b0;
                    if (mem_ready_i) begin
                        latch <= mem_q_i[8*cur_addr[1:0] +: 8];
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr_o    = RAM_BASE + MEM_ADDR_W'(cur_addr[15:2]);
    assign mem_byte_en_o = 4'b0001 << cur_addr[1:0];
    assign mem_data_o    = {4{cur_data}};

    // DOC register write strobe, one cycle after the bus write
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            doc_cs_n_o <= 1'b1;
            doc_data_o <= 8'h00;
        end else begin
            doc_cs_n_o <= ~(data_wr && !ram_mode);
            if (data_wr && !ram_mode) doc_data_o <= data_i;
        end
    end

    assign doc_addr_o = ptr[7:0];

    // Volume: mix * (vol+1) / 2^VOL_W, always within AUDIO_W
    logic [NUM_CH-1:0][AUDIO_W-1:0] audio_q;
    logic [VOL_W+1:0]               scale;

    assign scale = {2'b00, ctrl[VOL_W-1:0]} + (VOL_W+2)'(1);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_vol
        logic signed [AUDIO_W-1:0] mix_s;
        logic signed [PW-1:0]      prod;

        assign mix_s = mix_i[ch*AUDIO_W +: AUDIO_W];
        assign prod  = $signed({{(PW-AUDIO_W){mix_s[AUDIO_W-1]}}, mix_s}) *
                       $signed({{(PW-VOL_W-2){1'b0}}, scale});

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) audio_q[ch] <= '0;
            else            audio_q[ch] <= prod[VOL_W +: AUDIO_W];
        end
    end

    assign audio_o = audio_q;

endmodule

// File: tb/tb_sound_glu_engine.sv
// Directed bench for sound_glu_engine with a latency-programmable SDRAM responder.
module tb_sound_glu_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic        rw_n = 1'b1;
    logic        wr_strobe = 1'b0;
    logic        rd_strobe = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic [20:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q = 32'h0;
    logic        mem_ready = 1'b0;
    logic        doc_cs_n;
    logic [7:0]  doc_addr, doc_wdata;
    logic [7:0]  doc_rdata = 8'h00;
    logic [31:0] mix = 32'h0;
    logic [31:0] audio;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int lat = 5;
    bit hold = 1'b0;

    typedef struct {
        bit        rd;
        bit [20:0] waddr;
        bit [15:0] baddr;
        bit [3:0]  be;
        bit [7:0]  d;
    } log_t;

    log_t     log_q[$];
    bit [7:0] smem [65536];

    always #5 clk = ~clk;

    sound_glu_engine dut (
        .clk_i(clk), .reset_n_i(reset_n), .sel_i(sel), .reg_addr_i(reg_addr),
        .rw_n_i(rw_n), .wr_strobe_i(wr_strobe), .rd_strobe_i(rd_strobe),
        .data_i(din), .data_o(dout), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .mem_byte_en_o(mem_be), .mem_data_o(mem_wdata),
        .mem_q_i(mem_q), .mem_ready_i(mem_ready), .doc_cs_n_o(doc_cs_n),
        .doc_addr_o(doc_addr), .doc_data_o(doc_wdata), .doc_data_i(doc_rdata),
        .mix_i(mix), .audio_o(audio), .overflow_o(overflow)
    );

    // SDRAM responder: logs each request, answers after lat cycles unless held
    initial begin
        forever begin
            @(negedge clk);
            if (mem_wr || mem_rd) begin
                log_t e;
                int   lane;
                lane = (mem_be == 4'h2) ? 1 : (mem_be == 4'h4) ? 2 : (mem_be == 4'h8) ? 3 : 0;
                e.rd    = mem_rd;
                e.waddr = mem_addr;
                e.baddr = 16'((mem_addr - 21'h4000) << 2) | 16'(lane);
                e.be    = mem_be;
                e.d     = mem_wdata[8*lane +: 8];
                log_q.push_back(e);
                if (!e.rd) smem[e.baddr] = e.d;
                repeat (lat - 1) @(negedge clk);
                while (hold) @(negedge clk);
                mem_q = {smem[{e.baddr[15:2], 2'd3}], smem[{e.baddr[15:2], 2'd2}],
                         smem[{e.baddr[15:2], 2'd1}], smem[{e.baddr[15:2], 2'd0}]};
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; reg_addr = a; rw_n = 1'b0; din = d; wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0; sel = 1'b0; rw_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; reg_addr = a; rw_n = 1'b1;
        #1 d = dout;
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0; sel = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        reg_addr = a; rw_n = 1'b1;
        #1 d = dout;
    endtask

    task automatic wait_idle(input string tag);
        logic [7:0] c;
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            peek(2'd0, c);
            if (!c[7]) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s idle-timeout: busy still set after 300 cycles", tag);
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (doc_cs_n !== 1'b1) begin errors++; $display("FAIL rst_doc_cs got %b exp 1", doc_cs_n); end
        checks++; if (audio !== 32'h0) begin errors++; $display("FAIL rst_audio got %h exp 0", audio); end
        checks++; if (overflow !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rst_strobes got ovf=%b wr=%b rd=%b exp 0", overflow, mem_wr, mem_rd); end
        reset_n = 1'b1;
        @(negedge clk);
        peek(2'd0, v);
        checks++; if (v !== 8'h0F) begin errors++; $display("FAIL rst_ctrl got %h exp 0f", v); end
        peek(2'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", v); end
        peek(2'd2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ptr_lo got %h exp 00", v); end
        peek(2'd3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ptr_hi got %h exp 00", v); end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        logic [15:0] exp_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [3:0]  exp_be [3] = '{4'h4, 4'h8, 4'h1};
        logic [7:0]  exp_d [3] = '{8'h11, 8'h22, 8'h33};
        int base;
        lat = 5;
        bus_write(2'd0, 8'h6F);
        bus_write(2'd2, 8'hFE);
        bus_write(2'd3, 8'hFF);
        base = log_q.size();
        bus_write(2'd1, 8'h11);
        bus_write(2'd1, 8'h22);
        bus_write(2'd1, 8'h33);
        peek(2'd0, v);
        checks++; if (v[7] !== 1'b1) begin errors++; $display("FAIL wrap_busy_set got %b exp 1", v[7]); end
        wait_idle("wrap");
        checks++; if (log_q.size() - base != 3) begin
            errors++; $display("FAIL wrap_count got %0d exp 3", log_q.size() - base); end
        else begin
            checks++; if (log_q[base].waddr !== 21'h7FFF) begin
                errors++; $display("FAIL wrap_waddr got %h exp 7fff", log_q[base].waddr); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_q[base+i].rd || log_q[base+i].baddr !== exp_a[i] ||
                    log_q[base+i].be !== exp_be[i] || log_q[base+i].d !== exp_d[i]) begin
                    errors++;
                    $display("FAIL wrap_wr%0d got rd=%b a=%h be=%h d=%h exp rd=0 a=%h be=%h d=%h", i,
                             log_q[base+i].rd, log_q[base+i].baddr, log_q[base+i].be, log_q[base+i].d,
                             exp_a[i], exp_be[i], exp_d[i]);
                end
            end
        end
        peek(2'd2, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL wrap_ptr_lo got %h exp 01", v); end
        peek(2'd3, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap_ptr_hi got %h exp 00", v); end
    endtask

    task automatic test_overflow;
        logic [7:0] v;
        int base;
        lat = 2;
        bus_write(2'd0, 8'h6F);
        bus_write(2'd2, 8'h00);
        bus_write(2'd3, 8'h01);
        hold = 1'b1;
        base = log_q.size();
        for (int i = 1; i <= 5; i++) bus_write(2'd1, 8'(i));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        hold = 1'b0;
        wait_idle("ovf");
        checks++; if (log_q.size() - base != 4) begin
            errors++; $display("FAIL ovf_count got %0d exp 4", log_q.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[base+i].rd || log_q[base+i].baddr !== 16'h0100 + 16'(i) ||
                    log_q[base+i].d !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL ovf_wr%0d got a=%h d=%h exp a=%h d=%h", i, log_q[base+i].baddr,
                             log_q[base+i].d, 16'h0100 + 16'(i), 8'(i + 1));
                end
            end
        end
        peek(2'd2, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL ovf_ptr got %h exp 05", v); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        bus_write(2'd0, 8'h6F);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_raw;
        logic [7:0] v;
        int base;
        lat = 3;
        smem[16'h0041] = 8'h5A;
        bus_write(2'd0, 8'h4F);
        bus_write(2'd2, 8'h40);
        bus_write(2'd3, 8'h00);
        base = log_q.size();
        bus_write(2'd1, 8'hAA);
        bus_read(2'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL raw_first got %h exp 00", v); end
        wait_idle("raw1");
        checks++; if (log_q.size() - base != 2) begin
            errors++; $display("FAIL raw_count got %0d exp 2", log_q.size() - base); end
        else begin
            checks++; if (log_q[base].rd !== 1'b0 || log_q[base+1].rd !== 1'b1 ||
                          log_q[base+1].baddr !== 16'h0040 || log_q[base+1].be !== 4'h1) begin
                errors++; $display("FAIL raw_order got rd0=%b rd1=%b a1=%h be1=%h exp 0 1 0040 1",
                                   log_q[base].rd, log_q[base+1].rd, log_q[base+1].baddr, log_q[base+1].be);
            end
        end
        bus_read(2'd1, v);
        checks++; if (v !== 8'hAA) begin errors++; $display("FAIL raw_second got %h exp aa", v); end
        wait_idle("raw2");
        bus_write(2'd2, 8'h41);
        bus_read(2'd1, v);
        checks++; if (v !== 8'hAA) begin errors++; $display("FAIL raw_lane1_stale got %h exp aa", v); end
        wait_idle("raw3");
        bus_read(2'd1, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL raw_lane1 got %h exp 5a", v); end
        wait_idle("raw4");
    endtask

    task automatic test_doc;
        logic [7:0] v;
        int base;
        bus_write(2'd0, 8'h0F);
        bus_write(2'd2, 8'hE1);
        base = log_q.size();
        @(negedge clk);
        sel = 1'b1; reg_addr = 2'd1; rw_n = 1'b0; din = 8'h3C; wr_strobe = 1'b1;
        #1;
        checks++; if (doc_cs_n !== 1'b1) begin errors++; $display("FAIL doc_cs_early got %b exp 1", doc_cs_n); end
        @(negedge clk);
        wr_strobe = 1'b0; sel = 1'b0; rw_n = 1'b1;
        checks++; if (doc_cs_n !== 1'b0 || doc_addr !== 8'hE1 || doc_wdata !== 8'h3C) begin
            errors++; $display("FAIL doc_write got cs=%b a=%h d=%h exp 0 e1 3c", doc_cs_n, doc_addr, doc_wdata); end
        @(negedge clk);
        checks++; if (doc_cs_n !== 1'b1) begin errors++; $display("FAIL doc_cs_width got %b exp 1", doc_cs_n); end
        checks++; if (log_q.size() != base) begin errors++; $display("FAIL doc_no_mem got %0d exp 0", log_q.size() - base); end
        bus_write(2'd0, 8'h2F);
        doc_rdata = 8'h77;
        bus_read(2'd1, v);
        checks++; if (v !== 8'h77) begin errors++; $display("FAIL doc_read got %h exp 77", v); end
        peek(2'd2, v);
        checks++; if (v !== 8'hE2) begin errors++; $display("FAIL doc_autoinc got %h exp e2", v); end
        doc_rdata = 8'h00;
    endtask

    task automatic test_volume;
        logic [7:0]  vols [3] = '{8'h0F, 8'h07, 8'h00};
        logic [31:0] exps [3] = '{32'hC000_4000, 32'hE000_2000, 32'hFC00_0400};
        mix = 32'hC000_4000;
        for (int i = 0; i < 3; i++) begin
            bus_write(2'd0, vols[i]);
            repeat (2) @(negedge clk);
            checks++; if (audio !== exps[i]) begin
                errors++; $display("FAIL vol_%0d got %h exp %h", vols[i], audio, exps[i]); end
        end
        mix = 32'h4000_C000;
        #1;
        checks++; if (audio !== 32'hFC00_0400) begin errors++; $display("FAIL vol_hold got %h exp fc000400", audio); end
        @(negedge clk);
        checks++; if (audio !== 32'h0400_FC00) begin errors++; $display("FAIL vol_latency got %h exp 0400fc00", audio); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        int n;
        lat = 2;
        bus_write(2'd0, 8'h4F);
        bus_write(2'd2, 8'h00);
        bus_write(2'd3, 8'h02);
        hold = 1'b1;
        bus_write(2'd1, 8'h99);
        repeat (3) @(negedge clk);
        peek(2'd0, v);
        checks++; if (v[7] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", v[7]); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = log_q.size();
        hold = 1'b0;
        repeat (10) @(negedge clk);
        peek(2'd0, v);
        checks++; if (v !== 8'h0F) begin errors++; $display("FAIL mid_ctrl got %h exp 0f", v); end
        checks++; if (log_q.size() != n) begin errors++; $display("FAIL mid_no_retry got %0d exp 0", log_q.size() - n); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_overflow();
        test_raw();
        test_doc();
        test_volume();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
